clock_display_mux: RTL and testbench

Downstream consumer of the seconds/minutes counters. Converts the 6-bit binary minutes and seconds into four BCD digits and time-multiplexes them onto a common-anode 4-digit 7-segment display. It adds per-digit blanking to suppress ghosting and snapshots its inputs once per frame so a displayed value never tears.

---
 rtl/clock_display_mux.sv | 126 ++++++++++++
 tb/tb_clock_display_mux.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/clock_display_mux.sv
// clock_display_mux
//   Converts binary minutes/seconds (0..59) into four BCD digits and scans
//   them onto a common-anode 4-digit 7-segment display. Each digit slot is
//   DIGIT_CYCLES clocks long. The first cycle of each slot is dark so that
//   ghosting is suppressed. The inputs are snapshotted once per frame, at the
//   start of digit 0, so a frame never shows a torn value.
//
// Parameters
//   DIGIT_CYCLES  clk cycles per digit slot (>= 2)
//   BLANK_LEAD    1: the minutes-tens digit is dark while it would show 0
//
// Ports
//   clk         system clock, posedge
//   rst         synchronous reset, active-low
//   seconds     binary seconds, 0..59 valid (values > 59 show dashes)
//   minutes     binary minutes, 0..59 valid (values > 59 show dashes)
//   an          digit enables, active-low; an[0] = seconds ones .. an[3] = minutes tens
//   seg         segments, active-low, {g,f,e,d,c,b,a}
//   dp          decimal point, active-low; colon blink on digit 2
//   frame_done  one-cycle pulse at the end of every 4-digit frame
module clock_display_mux #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_LEAD   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int              CW      = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DIGIT_CYCLES - 1);
    localparam logic [6:0]      SEG_OFF  = 7'b1111111;
    localparam logic [6:0]      SEG_DASH = 7'b0111111;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [5:0]    s_sec;
    logic [5:0]    s_min;

    logic [5:0]    digit_val;
    logic          src_bad;
    logic          lead_dark;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    function automatic logic [6:0] encode(input logic [5:0] d);
        logic [6:0] r;
        case (d)
            6'd0:    r = 7'b1000000;
            6'd1:    r = 7'b1111001;
            6'd2:    r = 7'b0100100;
            6'd3:    r = 7'b0110000;
            6'd4:    r = 7'b0011001;
            6'd5:    r = 7'b0010010;
            6'd6:    r = 7'b0000010;
            6'd7:    r = 7'b1111000;
            6'd8:    r = 7'b0000000;
            6'd9:    r = 7'b0010000;
            default: r = SEG_DASH;
        endcase
        return r;
    endfunction

    always_comb begin
        digit_val = '0;
        case (idx)
            2'd0: digit_val = s_sec % 6'd10;
            2'd1: digit_val = s_sec / 6'd10;
            2'd2: digit_val = s_min % 6'd10;
            2'd3: digit_val = s_min / 6'd10;
            default: digit_val = '0;
        endcase

        // An out-of-range value dashes both digits it feeds.
        src_bad   = idx[1] ? (s_min > 6'd59) : (s_sec > 6'd59);
        // s_min/10 == 0 is the same as s_min < 10.
        lead_dark = (BLANK_LEAD != 0) && (idx == 2'd3) && (s_min < 6'd10);

        an_next  = '1;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (cnt != '0 && !lead_dark) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = src_bad ? SEG_DASH : encode(digit_val);
        end
        if (cnt != '0 && idx == 2'd2 && !s_sec[0])
            dp_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= '0;
            s_sec      <= '0;
            s_min      <= '0;
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (cnt == '0 && idx == 2'd0) begin
                s_sec <= seconds;
                s_min <= minutes;
            end

            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_done <= (cnt == CNT_MAX) && (idx == 2'd3);
        end
    end

endmodule

// File: tb/tb_clock_display_mux.sv
// Directed bench for clock_display_mux with DIGIT_CYCLES=4. Two instances
// share all inputs: dut_a has leading-zero blanking, dut_b does not.
module tb_clock_display_mux;

    logic       clk;
    logic       rst;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic       fd_a, fd_b;

    int vectors;
    int miscompares;

    localparam logic [6:0] S_OFF  = 7'b1111111;
    localparam logic [6:0] S_DASH = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;

    clock_display_mux #(.DIGIT_CYCLES(4), .BLANK_LEAD(1)) dut_a (
        .clk(clk), .rst(rst), .seconds(seconds), .minutes(minutes),
        .an(an_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a)
    );

    clock_display_mux #(.DIGIT_CYCLES(4), .BLANK_LEAD(0)) dut_b (
        .clk(clk), .rst(rst), .seconds(seconds), .minutes(minutes),
        .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks both instances for one clock against the given expected values.
    task automatic chk_all(input string tag,
                           input logic [3:0] ea_a, input logic [6:0] es_a,
                           input logic [3:0] ea_b, input logic [6:0] es_b,
                           input logic edp, input logic efd);
        chk({tag, " an_a"},  7'(an_a),  7'(ea_a));
        chk({tag, " seg_a"}, seg_a,     es_a);
        chk({tag, " dp_a"},  7'(dp_a),  7'(edp));
        chk({tag, " fd_a"},  7'(fd_a),  7'(efd));
        chk({tag, " an_b"},  7'(an_b),  7'(ea_b));
        chk({tag, " seg_b"}, seg_b,     es_b);
        chk({tag, " dp_b"},  7'(dp_b),  7'(edp));
        chk({tag, " fd_b"},  7'(fd_b),  7'(efd));
    endtask

    // Steps through a frame starting at the snapshot edge. Edge k (1..16) of
    // the frame shows slot (k-1)/4; the first edge of each slot is dark.
    // e0..e3 are the digit patterns, dp2 the expected colon level, lead_dark
    // whether dut_a blanks digit 3. At edge chg_at, seconds is changed to
    // chg_sec after checking.
    task automatic frame(input string tag,
                         input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3,
                         input logic dp2, input logic lead_dark,
                         input int nsteps, input int chg_at, input logic [5:0] chg_sec);
        logic [6:0] digs [4];
        digs[0] = e0; digs[1] = e1; digs[2] = e2; digs[3] = e3;
        for (int k = 1; k <= nsteps; k++) begin
            int         slot;
            logic       lit;
            logic [3:0] ea_a, ea_b;
            logic [6:0] es_a, es_b;
            logic       edp;
            step();
            slot = (k - 1) / 4;
            lit  = ((k - 1) % 4) != 0;
            ea_b = lit ? ~(4'b0001 << slot) : 4'b1111;
            es_b = lit ? digs[slot] : S_OFF;
            ea_a = ea_b;
            es_a = es_b;
            if (slot == 3 && lead_dark) begin
                ea_a = 4'b1111;
                es_a = S_OFF;
            end
            edp = (lit && slot == 2) ? dp2 : 1'b1;
            chk_all($sformatf("%s k%0d", tag, k), ea_a, es_a, ea_b, es_b, edp, k == 16);
            if (k == chg_at) seconds = chg_sec;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b0;
        minutes = 6'd12;
        seconds = 6'd34;

        // Held reset: outputs dark, no frame pulse.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("reset%0d", i), 4'b1111, S_OFF, 4'b1111, S_OFF, 1'b1, 1'b0);
        end

        // 12:34, seconds changes to 35 during digit-1 slot; frame keeps 34.
        rst = 1'b1;
        frame("f1234", S4, S3, S2, S1, 1'b0, 1'b0, 16, 6, 6'd35);

        // Next frame picks up 35: colon off.
        frame("f1235", S5, S3, S2, S1, 1'b1, 1'b0, 16, 0, 6'd0);

        // 05:35: dut_a darkens the leading zero, dut_b shows 0.
        minutes = 6'd5;
        frame("f0535", S5, S3, S5, S0, 1'b1, 1'b1, 16, 0, 6'd0);

        // Out-of-range seconds: dashes on digits 0/1; 60 is even so colon on.
        seconds = 6'd60;
        minutes = 6'd59;
        frame("f5960", S_DASH, S_DASH, S9, S5, 1'b0, 1'b0, 16, 0, 6'd0);

        // Reset mid-frame while idx==2, then a fresh frame with 12:47.
        seconds = 6'd34;
        minutes = 6'd12;
        frame("fpart", S4, S3, S2, S1, 1'b0, 1'b0, 10, 0, 6'd0);
        rst = 1'b0;
        step();
        chk_all("midrst", 4'b1111, S_OFF, 4'b1111, S_OFF, 1'b1, 1'b0);
        rst     = 1'b1;
        seconds = 6'd47;
        frame("f1247", S7, S4, S2, S1, 1'b1, 1'b0, 16, 0, 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
